frog_point_register: RTL and testbench

Datapath responder for the frog point controller. It consumes the controller's active-low clear/load strobes and 2-bit shift selection, and holds the frog position as a row index plus a one-hot column. It returns the status signals the controller branches on: bottom-side, last-register/goal/collision and losing. It sits between the point controller and the display/hazard lanes in the game top level.

---
 rtl/frog_point_pkg.sv | 14 +
 rtl/frog_hazard_row_select.sv | 29 ++
 rtl/frog_point_register.sv | 98 +++++++++
 tb/tb_frog_point_register.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_point_pkg.sv
// Shared constants for the frog point controller and its datapath responder.
// Shift encodings, the idle status code, and the default playfield size.
package frog_point_pkg;

    localparam logic [1:0] SHIFT_LEFT     = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT    = 2'b10;
    localparam logic [1:0] SHIFT_HOLD     = 2'b11;

    localparam logic [1:0] LASTREG_NORMAL = 2'b11;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

endpackage

// File: rtl/frog_hazard_row_select.sv
// Selects the hazard row at the frog's row and flags overlap with the frog's column.
// Purely combinational; shared with the display overlay.
module frog_hazard_row_select
    import frog_point_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [ROWS*COLS-1:0]     i_hazard,
    input  logic [$clog2(ROWS)-1:0]  i_row,
    input  logic [COLS-1:0]          i_col,
    output logic                     o_hit
);

    logic [COLS-1:0] w_slice;

    // Explicit mux keeps out-of-range row codes (non power-of-two ROWS) hazard-free.
    always_comb begin
        w_slice = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(i_row) == r) begin
                w_slice = i_hazard[r*COLS +: COLS];
            end
        end
    end

    assign o_hit = |(w_slice & i_col);

endmodule

// File: rtl/frog_point_register.sv
// Frog position/lives register answering the point controller's active-low strobes.
// Define FROG_POINT_WRAP_EN to make horizontal shifts rotate instead of holding at the edge.
module frog_point_register
    import frog_point_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int START_COL = 3,
    parameter int LIVES     = 3
) (
    input  logic                          SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                          SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                          clear_InLow,
    input  logic                          load0_InLow,
    input  logic                          load1_InLow,
    input  logic [1:0]                    shiftselection_In,
    input  logic [ROWS*COLS-1:0]          hazard_In,
    output logic [$clog2(ROWS)-1:0]       row_Out,
    output logic [COLS-1:0]               col_Out,
    output logic [$clog2(LIVES+1)-1:0]    lives_Out,
    output logic                          bottomside_OutLow,
    output logic [1:0]                    lastregister_OutLow,
    output logic                          losing_OutLow
);

    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(LIVES+1);

    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS-1);
    localparam logic [COLS-1:0] COL_START  = {{(COLS-1){1'b0}}, 1'b1} << START_COL;
    localparam logic [LW-1:0]   LIVES_FULL = LW'(LIVES);

    logic [RW-1:0]   r_row;
    logic [COLS-1:0] r_col;
    logic            r_collide;
    logic [LW-1:0]   r_lives;

    logic            w_hit;
    logic [COLS-1:0] w_col_left;
    logic [COLS-1:0] w_col_right;

    frog_hazard_row_select #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_select (
        .i_hazard (hazard_In),
        .i_row    (r_row),
        .i_col    (r_col),
        .o_hit    (w_hit)
    );

`ifdef FROG_POINT_WRAP_EN
    assign w_col_left  = {r_col[COLS-2:0], r_col[COLS-1]};
    assign w_col_right = {r_col[0], r_col[COLS-1:1]};
`else
    assign w_col_left  = r_col[COLS-1] ? r_col : {r_col[COLS-2:0], 1'b0};
    assign w_col_right = r_col[0]      ? r_col : {1'b0, r_col[COLS-1:1]};
`endif

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            r_row     <= ROW_LAST;
            r_col     <= COL_START;
            r_collide <= 1'b0;
            r_lives   <= LIVES_FULL;
        end else if (!clear_InLow) begin
            r_row     <= ROW_LAST;
            r_col     <= COL_START;
            r_collide <= 1'b0;
            if (r_lives == '0) begin
                r_lives <= LIVES_FULL;
            end
        end else begin
            if (!load0_InLow) begin
                if (r_row != '0) r_row <= r_row - 1'b1;
            end else if (!load1_InLow) begin
                if (r_row != ROW_LAST) r_row <= r_row + 1'b1;
            end else if (shiftselection_In == SHIFT_LEFT) begin
                r_col <= w_col_left;
            end else if (shiftselection_In == SHIFT_RIGHT) begin
                r_col <= w_col_right;
            end
            // Only the rising edge of the sticky flag costs a life.
            if (w_hit && !r_collide) begin
                r_collide <= 1'b1;
                if (r_lives != '0) r_lives <= r_lives - 1'b1;
            end
        end
    end

    assign row_Out             = r_row;
    assign col_Out             = r_col;
    assign lives_Out           = r_lives;
    assign bottomside_OutLow   = (r_row != ROW_LAST);
    assign lastregister_OutLow = {~r_collide, (r_row != '0)};
    assign losing_OutLow       = (r_lives != '0);

endmodule

// File: tb/tb_frog_point_register.sv
// Scoreboard bench for frog_point_register at ROWS=8, COLS=8, START_COL=3, LIVES=3.
module tb_frog_point_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_n = 1'b1;
    logic        l0_n = 1'b1;
    logic        l1_n = 1'b1;
    logic [1:0]  sh = 2'b00;
    logic [63:0] haz = '0;

    logic [2:0]  row_o;
    logic [7:0]  col_o;
    logic [1:0]  lives_o;
    logic        bot_o;
    logic [1:0]  lr_o;
    logic        los_o;

    typedef struct {
        logic [2:0] row;
        logic [7:0] col;
        logic [1:0] lives;
        logic       bot;
        logic [1:0] lr;
        logic       los;
    } exp_t;

    exp_t exp_q[$];

    int          m_row;
    logic [7:0]  m_col;
    logic        m_coll;
    int          m_lives;

    int total = 0;
    int bad   = 0;

    frog_point_register #(
        .ROWS(8), .COLS(8), .START_COL(3), .LIVES(3)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .clear_InLow                       (clr_n),
        .load0_InLow                       (l0_n),
        .load1_InLow                       (l1_n),
        .shiftselection_In                 (sh),
        .hazard_In                         (haz),
        .row_Out                           (row_o),
        .col_Out                           (col_o),
        .lives_Out                         (lives_o),
        .bottomside_OutLow                 (bot_o),
        .lastregister_OutLow               (lr_o),
        .losing_OutLow                     (los_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.row   = 3'(m_row);
        e.col   = m_col;
        e.lives = 2'(m_lives);
        e.bot   = (m_row != 7);
        e.lr    = {~m_coll, (m_row != 0)};
        e.los   = (m_lives != 0);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        chk("row",     32'(row_o),   32'(e.row));
        chk("col",     32'(col_o),   32'(e.col));
        chk("lives",   32'(lives_o), 32'(e.lives));
        chk("bottom",  32'(bot_o),   32'(e.bot));
        chk("lastreg", 32'(lr_o),    32'(e.lr));
        chk("losing",  32'(los_o),   32'(e.los));
    endtask

    task automatic model_reset();
        m_row   = 7;
        m_col   = 8'h08;
        m_coll  = 1'b0;
        m_lives = 3;
    endtask

    task automatic model_step(input logic c_n, input logic a_n, input logic b_n,
                              input logic [1:0] s, input logic [63:0] h);
        logic [7:0] slice;
        logic       hit;
        slice = h[m_row*8 +: 8];
        hit   = |(slice & m_col);
        if (!c_n) begin
            m_row  = 7;
            m_col  = 8'h08;
            m_coll = 1'b0;
            if (m_lives == 0) m_lives = 3;
        end else begin
            if (!a_n) begin
                if (m_row > 0) m_row = m_row - 1;
            end else if (!b_n) begin
                if (m_row < 7) m_row = m_row + 1;
            end else if (s == 2'b01) begin
`ifdef FROG_POINT_WRAP_EN
                m_col = m_col[7] ? 8'h01 : (m_col << 1);
`else
                m_col = m_col[7] ? m_col : (m_col << 1);
`endif
            end else if (s == 2'b10) begin
`ifdef FROG_POINT_WRAP_EN
                m_col = m_col[0] ? 8'h80 : (m_col >> 1);
`else
                m_col = m_col[0] ? m_col : (m_col >> 1);
`endif
            end
            if (hit && !m_coll) begin
                m_coll = 1'b1;
                if (m_lives > 0) m_lives = m_lives - 1;
            end
        end
    endtask

    task automatic step(input logic c_n, input logic a_n, input logic b_n,
                        input logic [1:0] s, input logic [63:0] h);
        @(negedge clk);
        clr_n = c_n; l0_n = a_n; l1_n = b_n; sh = s; haz = h;
        model_step(c_n, a_n, b_n, s, h);
        exp_q.push_back(snap());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle(input logic [63:0] h);
        step(1'b1, 1'b1, 1'b1, 2'b00, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b1; l0_n = 1'b1; l1_n = 1'b1; sh = 2'b00; haz = '0;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(snap());
        #1;
        compare_out();
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [63:0] HAZ_START = 64'd1 << (7*8+3);

    initial begin
        do_reset();
        idle('0);

        // Climb to the goal row and try to go past it.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        end
        idle('0);
        step(1'b0, 1'b1, 1'b1, 2'b00, '0);

        // Down at the bottom holds; left shifts saturate (or rotate).
        step(1'b1, 1'b1, 1'b0, 2'b00, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 2'b01, '0);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b1, 2'b10, '0);
        end
        step(1'b1, 1'b1, 1'b1, 2'b11, '0);
        step(1'b0, 1'b1, 1'b1, 2'b00, '0);

        // Single collision held for several cycles costs one life.
        for (int i = 0; i < 4; i++) begin
            idle(HAZ_START);
        end
        step(1'b0, 1'b1, 1'b1, 2'b00, '0);
        idle('0);

        // Drain all lives then recover on clear.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(HAZ_START);
            idle('0);
            step(1'b0, 1'b1, 1'b1, 2'b00, '0);
        end
        for (int k = 0; k < 3; k++) begin
            idle(HAZ_START);
            idle('0);
            idle('0);
            step(1'b0, 1'b1, 1'b1, 2'b00, '0);
        end

        // Clear coinciding with a hit: clear wins.
        step(1'b0, 1'b1, 1'b1, 2'b00, HAZ_START);
        idle('0);

        // Reset in the middle of an upward move.
        step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        @(negedge clk);
        l0_n = 1'b0;
        #5;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(snap());
        #1;
        compare_out();
        @(negedge clk);
        l0_n = 1'b1;
        rst  = 1'b0;
        idle('0);

        // Random single-strobe traffic with sparse hazards.
        for (int i = 0; i < 300; i++) begin
            logic       c_n, a_n, b_n;
            logic [1:0] s;
            logic [63:0] h;
            int          pick;
            c_n = 1'b1; a_n = 1'b1; b_n = 1'b1; s = 2'b00;
            pick = $urandom_range(0, 9);
            case (pick)
                0:       c_n = 1'b0;
                1, 2:    a_n = 1'b0;
                3:       b_n = 1'b0;
                4, 5:    s = 2'b01;
                6, 7:    s = 2'b10;
                default: s = 2'($urandom_range(0, 3));
            endcase
            h = ($urandom_range(0, 2) == 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
            if ($urandom_range(0, 5) == 0) h = h | ({56'd0, m_col} << (m_row*8));
            step(c_n, a_n, b_n, s, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
